spi_tqv_bridge: RTL and testbench
=================================

SPI_TQV_BRIDGE -- requirements
Module: spi_tqv_bridge

Interface
REQ-001 Parameter ADDR_W, default 6, peripheral address width.
REQ-002 Parameter TIMEOUT_CYCLES, default 255, read-wait limit in clk cycles (used only with SPI_BRIDGE_TIMEOUT_EN).
REQ-003 clk  input  1  sole clock; all state changes on rising edge.
REQ-004 rst_n  input  1  reset, synchronous, active-low.
REQ-005 spi_cs_n  input  1  SPI chip select, active-low, already synchronised to clk.
REQ-006 spi_clk  input  1  SPI clock, mode 0, already synchronised.
REQ-007 spi_mosi  input  1  SPI data in, already synchronised.
REQ-008 spi_miso  output  1  SPI data out.
REQ-009 address  output  ADDR_W  peripheral register address.
REQ-010 data_in  output  32  write data to peripheral.
REQ-011 data_write_n  output  2  write strobe: 00=8b, 01=16b, 10=32b, 11=idle.
REQ-012 data_read_n  output  2  read request, same encoding.
REQ-013 data_out  input  32  read data from peripheral.
REQ-014 data_ready  input  1  peripheral read-data valid.
REQ-015 busy  output  1  high from header completion until the transaction completes or aborts.

Function
REQ-016 SPI edges SHALL be detected by comparing spi_clk against its registered previous value; MOSI sampled on the detected rising edge, MISO updated on the detected falling edge; MSB first.
REQ-017 Header SHALL be 16 bits: byte0 = {rw, 5'b0, txn[1:0]} (rw=1 write), byte1 = {2'b0, addr[5:0]}.
REQ-018 FSM states: IDLE, HDR, WDATA, WSTROBE, RREQ, RDATA, DRAIN; spi_cs_n falling moves IDLE->HDR with bit counter cleared.
REQ-019 txn=11 SHALL go HDR->DRAIN: no strobe, no read, remaining bits ignored until spi_cs_n high.
REQ-020 Write: WDATA SHALL shift 8/16/32 bits for txn 00/01/10, right-aligned in data_in with upper bits zero; last bit -> WSTROBE.
REQ-021 WSTROBE SHALL drive data_write_n=txn for exactly one clk cycle, then go DRAIN; address and data_in held until next header completes.
REQ-022 Read: on header completion, RREQ SHALL drive data_read_n=txn continuously until data_ready is sampled high; that same cycle data_out is captured with bits above the width masked to zero, data_read_n returns to 11 the next cycle, state -> RDATA.
REQ-023 RDATA SHALL present captured bit [width-1] on spi_miso immediately and shift one bit per SPI falling edge; after width bits -> DRAIN, spi_miso=0.
REQ-024 SPI clocks during RREQ SHALL be ignored; spi_miso=0 during RREQ.
REQ-025 spi_cs_n high in any state SHALL return to IDLE next cycle, force data_write_n=data_read_n=11, busy=0; a partially shifted write SHALL issue no strobe.
REQ-026 spi_cs_n high and last-bit edge in the same cycle: abort wins, no strobe.
REQ-027 busy SHALL be 0 in IDLE, HDR and DRAIN, 1 otherwise.

Reset
REQ-028 With rst_n low at a clk edge: state IDLE, spi_miso=0, address=0, data_in=0, data_write_n=11, data_read_n=11, busy=0, counters and shift registers 0.
REQ-029 Reset mid-transaction SHALL abandon it with no strobe; bridge then waits for spi_cs_n high before accepting a new header.

Configuration
REQ-030 Macro SPI_BRIDGE_TIMEOUT_EN defined: an 8-bit counter SHALL run in RREQ; after TIMEOUT_CYCLES cycles without data_ready, data_read_n -> 11 and the captured value is 0xFFFFFFFF masked to width, state -> RDATA.
REQ-031 Macro undefined: no counter; RREQ waits indefinitely for data_ready or spi_cs_n high.

Verification
REQ-032 Write: CS low, shift 0x82, 0x05, 0x12345678 -> exactly one cycle with data_write_n=10, address=0x05, data_in=0x12345678; data_read_n stays 11.
REQ-033 Read 8-bit: shift 0x00, 0x3F; data_ready asserted 3 cycles later with data_out=0xAABBCCDD -> data_read_n=00 for those 3 cycles plus the ready cycle, MISO returns 0xDD.
REQ-034 Abort: shift 0x81, 0x01, 0x12, then raise CS -> no write strobe, busy=0, state IDLE next cycle.
REQ-035 Reserved width: header 0x83, 0x02 plus 32 bits -> no strobe, no read request.
REQ-036 Timeout (macro on): read header 0x01, 0x04, data_ready held low -> data_read_n=01 for 255 cycles, MISO returns 0xFFFF.
REQ-037 Reset during RREQ -> data_read_n=11 next cycle; new header ignored until CS has gone high.

Source files
------------

// File: rtl/spi_tqv_bridge.sv
// spi_tqv_bridge: SPI (mode 0, MSB first) slave to TinyQV-style peripheral register bridge.
// Ports: clk, rst_n (sync, active-low); spi_cs_n/spi_clk/spi_mosi in (pre-synchronised), spi_miso out;
//   address/data_in/data_write_n/data_read_n to the peripheral, data_out/data_ready from it; busy status.
// Header: byte0 = {rw, 5'b0, txn[1:0]}, byte1 = {2'b0, addr[5:0]}; txn 00/01/10 = 8/16/32 bits, 11 = no-op.
// Optional SPI_BRIDGE_TIMEOUT_EN: read wait gives up after TIMEOUT_CYCLES and returns all-ones.
module spi_tqv_bridge #(
  parameter int ADDR_W = 6,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              spi_cs_n,
  input  logic              spi_clk,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic [ADDR_W-1:0] address,
  output logic [31:0]       data_in,
  output logic [1:0]        data_write_n,
  output logic [1:0]        data_read_n,
  input  logic [31:0]       data_out,
  input  logic              data_ready,
  output logic              busy
);
  typedef enum logic [2:0] {IDLE, HDR, WDATA, WSTROBE, RREQ, RDATA, DRAIN} state_t;
  state_t state, state_n;
  logic sclk_q, cs_q, rise, fall, hdr_done, last_bit, timeout;
  logic [5:0] cnt, last_idx;
  logic [31:0] sh;
  logic [1:0] txn;
  // Read data is stored left-aligned so the outgoing bit is always sh[31].
  function automatic logic [31:0] align(input logic [1:0] t, input logic [31:0] v);
    return t == 2'b00 ? {v[7:0], 24'b0} : t == 2'b01 ? {v[15:0], 16'b0} : v;
  endfunction
  assign rise = spi_clk & ~sclk_q;
  assign fall = ~spi_clk & sclk_q;
  // Before the 16th header bit shifts in, sh[14:0] holds header bits 15..1.
  assign hdr_done = state == HDR && rise && cnt == 6'd15;
  assign last_idx = txn == 2'b00 ? 6'd7 : txn == 2'b01 ? 6'd15 : 6'd31;
  assign last_bit = cnt == last_idx;
`ifdef SPI_BRIDGE_TIMEOUT_EN
  logic [7:0] tmo;
  always_ff @(posedge clk)
    if (!rst_n) tmo <= '0;
    else tmo <= state == RREQ ? tmo + 8'd1 : 8'd0;
  assign timeout = tmo == 8'(TIMEOUT_CYCLES - 1);
`else
  assign timeout = TIMEOUT_CYCLES < 0;
`endif
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  // Chip select high aborts from anywhere; this also beats a last-bit edge in the same cycle.
  always_comb begin
    state_n = state;
    if (spi_cs_n) state_n = IDLE;
    else case (state)
      IDLE:    state_n = cs_q ? HDR : IDLE;
      HDR:     if (hdr_done) state_n = sh[8:7] == 2'b11 ? DRAIN : sh[14] ? WDATA : RREQ;
      WDATA:   if (rise && last_bit) state_n = WSTROBE;
      WSTROBE: state_n = DRAIN;
      RREQ:    if (data_ready || timeout) state_n = RDATA;
      RDATA:   if (fall && last_bit) state_n = DRAIN;
      default: state_n = state;
    endcase
  end
  // cs_q resets low so a header is only accepted after chip select has been seen high.
  always_ff @(posedge clk)
    if (!rst_n) begin
      sclk_q <= 1'b0;
      cs_q <= 1'b0;
      cnt <= '0;
      sh <= '0;
      txn <= '0;
      address <= '0;
      data_in <= '0;
    end else begin
      sclk_q <= spi_clk;
      cs_q <= spi_cs_n;
      if (spi_cs_n || state == IDLE) cnt <= '0;
      else if (hdr_done) begin
        cnt <= '0;
        txn <= sh[8:7];
        address <= ADDR_W'({sh[4:0], spi_mosi});
        if (sh[14]) data_in <= '0;
      end else if (state == HDR && rise) begin
        sh <= {sh[30:0], spi_mosi};
        cnt <= cnt + 6'd1;
      end else if (state == WDATA && rise) begin
        data_in <= {data_in[30:0], spi_mosi};
        cnt <= cnt + 6'd1;
      end else if (state == RREQ && (data_ready || timeout)) sh <= align(txn, data_ready ? data_out : '1);
      else if (state == RDATA && fall) begin
        sh <= {sh[30:0], 1'b0};
        cnt <= cnt + 6'd1;
      end
    end
  assign data_write_n = state == WSTROBE ? txn : 2'b11;
  assign data_read_n = state == RREQ ? txn : 2'b11;
  assign busy = state == WDATA || state == WSTROBE || state == RREQ || state == RDATA;
  assign spi_miso = state == RDATA && sh[31];
endmodule

// File: tb/tb_spi_tqv_bridge.sv
// tb_spi_tqv_bridge: randomized scoreboard bench for spi_tqv_bridge.
module tb_spi_tqv_bridge;
  logic clk = 0, rst_n = 0, spi_cs_n = 1, spi_clk = 0, spi_mosi = 0, data_ready = 0;
  logic [31:0] data_out = 0;
  logic spi_miso, busy;
  logic [5:0] address;
  logic [31:0] data_in;
  logic [1:0] data_write_n, data_read_n;
  int checks = 0, errors = 0;
  typedef struct {logic [1:0] txn; logic [5:0] addr; logic [31:0] data;} wr_t;
  typedef struct {logic [1:0] txn; int n;} rq_t;
  wr_t exp_wr[$];
  rq_t exp_rq[$];
  logic [31:0] exp_rd[$], got_rd[$];
  always #5 clk = ~clk;
  spi_tqv_bridge dut (
    .clk(clk), .rst_n(rst_n), .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .address(address), .data_in(data_in), .data_write_n(data_write_n),
    .data_read_n(data_read_n), .data_out(data_out), .data_ready(data_ready), .busy(busy)
  );
  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask
  function automatic int width(input logic [1:0] t);
    return t == 2'b00 ? 8 : t == 2'b01 ? 16 : 32;
  endfunction
  function automatic logic [31:0] mask(input logic [1:0] t);
    return t == 2'b00 ? 32'hFF : t == 2'b01 ? 32'hFFFF : 32'hFFFF_FFFF;
  endfunction
  task automatic monitor();
    int rq_n = 0;
    logic [1:0] rq_txn = 2'b11;
    wr_t w;
    rq_t q;
    forever begin
      @(negedge clk);
      if (data_write_n != 2'b11) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write got %b expected 11", data_write_n);
        end else begin
          w = exp_wr.pop_front();
          check("wr_txn", 32'(data_write_n), 32'(w.txn));
          check("wr_addr", 32'(address), 32'(w.addr));
          check("wr_data", data_in, w.data);
          check("rd_idle_during_wr", 32'(data_read_n), 32'h3);
        end
      end
      if (data_read_n != 2'b11) begin
        rq_n++;
        rq_txn = data_read_n;
      end else if (rq_n > 0) begin
        if (exp_rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_read got %0d cycles expected none", rq_n);
        end else begin
          q = exp_rq.pop_front();
          check("rq_txn", 32'(rq_txn), 32'(q.txn));
          check("rq_cycles", rq_n, q.n);
        end
        rq_n = 0;
      end
      if (got_rd.size() > 0 && exp_rd.size() > 0) check("miso_word", got_rd.pop_front(), exp_rd.pop_front());
    end
  endtask
  task automatic spi_bit(input logic b, output logic m);
    spi_mosi = b;
    repeat (2) @(negedge clk);
    m = spi_miso;
    spi_clk = 1;
    repeat (2) @(negedge clk);
    spi_clk = 0;
    repeat (2) @(negedge clk);
  endtask
  task automatic shift(input logic [31:0] v, input int n, output logic [31:0] r);
    logic m;
    r = 0;
    for (int i = n - 1; i >= 0; i--) begin
      spi_bit(v[i], m);
      r = {r[30:0], m};
    end
  endtask
  task automatic header(input logic rw, input logic [1:0] t, input logic [5:0] a);
    logic [31:0] r;
    spi_cs_n = 0;
    repeat (2) @(negedge clk);
    shift({16'b0, rw, 5'b0, t, 2'b0, a}, 16, r);
  endtask
  task automatic end_txn();
    spi_cs_n = 1;
    repeat (4) @(negedge clk);
  endtask
  task automatic do_write(input logic [1:0] t, input logic [5:0] a, input logic [31:0] v);
    logic [31:0] r;
    header(1'b1, t, a);
    if (t == 2'b11) begin
      check("busy_reserved_wr", 32'(busy), 0);
      shift(v, 32, r);
    end else begin
      check("busy_wdata", 32'(busy), 1);
      exp_wr.push_back('{t, a, v & mask(t)});
      shift(v, width(t), r);
    end
    end_txn();
  endtask
  // Header timing of spi_bit leaves 4 request cycles before the bench regains control.
  task automatic do_read(input logic [1:0] t, input logic [5:0] a, input int d, input logic [31:0] v);
    logic [31:0] r;
    header(1'b0, t, a);
    if (t == 2'b11) begin
      check("busy_reserved_rd", 32'(busy), 0);
      shift($urandom, 32, r);
    end else begin
      check("busy_rreq", 32'(busy), 1);
      exp_rq.push_back('{t, 4 + d});
      repeat (d) @(negedge clk);
      data_out = v;
      data_ready = 1;
      @(negedge clk);
      data_ready = 0;
      exp_rd.push_back(v & mask(t));
      shift($urandom, width(t), r);
      got_rd.push_back(r);
    end
    end_txn();
  endtask
  initial begin
    logic [31:0] r;
    fork
      monitor();
    join_none
    rst_n = 0;
    repeat (3) @(negedge clk);
    check("rst_miso", 32'(spi_miso), 0);
    check("rst_address", 32'(address), 0);
    check("rst_data_in", data_in, 0);
    check("rst_write_n", 32'(data_write_n), 3);
    check("rst_read_n", 32'(data_read_n), 3);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1;
    repeat (3) @(negedge clk);
    do_write(2'b10, 6'h05, 32'h1234_5678);
    do_read(2'b00, 6'h3F, 3, 32'hAABB_CCDD);
    header(1'b1, 2'b01, 6'h01);
    check("busy_before_abort", 32'(busy), 1);
    shift(32'h12, 8, r);
    spi_cs_n = 1;
    @(negedge clk);
    check("busy_after_abort", 32'(busy), 0);
    repeat (3) @(negedge clk);
    header(1'b1, 2'b00, 6'h2A);
    shift(32'h5A, 7, r);
    spi_mosi = 1;
    repeat (2) @(negedge clk);
    spi_clk = 1;
    spi_cs_n = 1;
    @(negedge clk);
    check("busy_abort_last_bit", 32'(busy), 0);
    spi_clk = 0;
    repeat (4) @(negedge clk);
    do_write(2'b11, 6'h02, 32'hDEAD_BEEF);
    header(1'b0, 2'b00, 6'h10);
    exp_rq.push_back('{2'b00, 4});
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    check("rst_rreq_read_n", 32'(data_read_n), 3);
    check("rst_rreq_busy", 32'(busy), 0);
    header(1'b1, 2'b10, 6'h05);
    shift(32'hCAFE_F00D, 32, r);
    check("busy_hdr_ignored", 32'(busy), 0);
    end_txn();
    do_write(2'b01, 6'h21, 32'h0000_BEEF);
`ifdef SPI_BRIDGE_TIMEOUT_EN
    header(1'b0, 2'b01, 6'h04);
    exp_rq.push_back('{2'b01, 255});
    repeat (260) @(negedge clk);
    exp_rd.push_back(32'hFFFF);
    shift($urandom, 16, r);
    got_rd.push_back(r);
    end_txn();
`endif
    for (int i = 0; i < 16; i++) begin
      logic [1:0] t = 2'($urandom_range(0, 3));
      logic [5:0] a = 6'($urandom);
      logic [31:0] v = $urandom;
      if ($urandom_range(0, 1) == 1) do_write(t, a, v);
      else do_read(t, a, $urandom_range(0, 10), v);
    end
    repeat (6) @(negedge clk);
    check("wr_queue_drained", exp_wr.size(), 0);
    check("rq_queue_drained", exp_rq.size(), 0);
    check("rd_queue_drained", exp_rd.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
